// File: rtl/queue_arbiter_pkg.sv
// rtl/queue_arbiter_pkg.sv - shared parameters, types and helpers for the event queue arbiter
package queue_arbiter_pkg;

  localparam int N_REQ  = 3;
  localparam int DEPTH  = 5;
  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic signed [DATA_W-1:0] event_t;
  typedef logic [CNT_W-1:0]         cnt_t;
  typedef logic [IDX_W-1:0]         idx_t;

  // Next requester index after i, wrapping at N_REQ
  function automatic idx_t next_idx(idx_t i);
    if (int'(i) >= N_REQ - 1) begin
      return '0;
    end
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/queue_arbiter_if.sv
// rtl/queue_arbiter_if.sv - producer, consumer and queue command bundle of the arbiter
interface queue_arbiter_if;
  import queue_arbiter_pkg::*;

  // producers
  logic   [N_REQ-1:0] req_valid;
  event_t [N_REQ-1:0] req_data;
  logic   [N_REQ-1:0] req_ready;

  // consumer
  logic               cons_valid;
  logic               cons_ready;
  event_t             cons_data;

  // queue command/acknowledge
  logic               q_push;
  logic               q_pop;
  event_t             q_data;
  logic               q_push_valid;
  logic               q_pop_valid;
  event_t             q_out;

  // controller side
  modport master (
    input  req_valid, req_data, cons_ready, q_push_valid, q_pop_valid, q_out,
    output req_ready, cons_valid, cons_data, q_push, q_pop, q_data
  );

  // producers, consumer and queue side
  modport slave (
    output req_valid, req_data, cons_ready, q_push_valid, q_pop_valid, q_out,
    input  req_ready, cons_valid, cons_data, q_push, q_pop, q_data
  );

endinterface

// File: rtl/queue_arbiter_rr_arbiter.sv
// rtl/queue_arbiter_rr_arbiter.sv - combinational round-robin winner select
module queue_arbiter_rr_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int N   = N_REQ,
  parameter int IDX_W_P = IDX_W
) (
  input  logic [N-1:0]       req_valid_i,
  input  logic [IDX_W_P-1:0] rr_i,
  output logic [IDX_W_P-1:0] winner_o,
  output logic               any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate requests so the pointer sits at bit 0, then take the lowest set bit
  always_comb begin
    int sum;
    sum      = 0;
    dbl      = {req_valid_i, req_valid_i};
    rot      = N'(dbl >> rr_i);
    winner_o = rr_i;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(rr_i) + k;
        if (sum >= N) begin
          sum = sum - N;
        end
        winner_o = IDX_W_P'(sum);
      end
    end
  end

  assign any_o = |req_valid_i;

endmodule

// File: rtl/queue_arbiter.sv
// rtl/queue_arbiter.sv - round-robin push arbiter and pop controller for the shared event queue
module queue_arbiter
  import queue_arbiter_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  queue_arbiter_if.master bus,
  output cnt_t            count_o,
  output logic            err_o
);

  idx_t   rr_q, rr_d;
  cnt_t   count_q, count_d;
  logic   cons_valid_q, cons_valid_d;
  event_t cons_data_q, cons_data_d;
  logic   err_q, err_d;

  idx_t             winner;
  logic             any_req;
  logic             push_go;
  logic             pop_go;
  logic [N_REQ-1:0] grant;

  queue_arbiter_rr_arbiter #(
    .N       (N_REQ),
    .IDX_W_P (IDX_W)
  ) u_rr_arbiter (
    .req_valid_i (bus.req_valid),
    .rr_i        (rr_q),
    .winner_o    (winner),
    .any_o       (any_req)
  );

  // Pop whenever something is queued and the output register is free or draining;
  // push only below capacity, a same-cycle pop does not make room
  always_comb begin
    pop_go  = en_i && (count_q != '0) && (!cons_valid_q || bus.cons_ready);
    push_go = en_i && (count_q < cnt_t'(DEPTH)) && any_req;
  end

  // One-hot grant to the round-robin winner when a push is issued
  always_comb begin
    grant = '0;
    if (push_go) begin
      grant[winner] = 1'b1;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.q_push     = push_go;
  assign bus.q_pop      = pop_go;
  assign bus.q_data     = bus.req_data[winner];
  assign bus.cons_valid = cons_valid_q;
  assign bus.cons_data  = cons_data_q;
  assign count_o        = count_q;
  assign err_o          = err_q;

  // Next state: everything holds while disabled; count tracks issued commands only
  always_comb begin
    rr_d         = rr_q;
    count_d      = count_q;
    cons_valid_d = cons_valid_q;
    cons_data_d  = cons_data_q;
    err_d        = err_q;
    if (en_i) begin
      if (push_go) begin
        rr_d = next_idx(winner);
      end
      count_d = count_q + cnt_t'(push_go) - cnt_t'(pop_go);
      if (pop_go) begin
        cons_valid_d = 1'b1;
        cons_data_d  = bus.q_out;
      end else if (bus.cons_ready) begin
        cons_valid_d = 1'b0;
      end
      if ((bus.q_push_valid != push_go) || (bus.q_pop_valid != pop_go)) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear, shared with the queue instance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      count_q      <= '0;
      cons_valid_q <= 1'b0;
      cons_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      count_q      <= count_d;
      cons_valid_q <= cons_valid_d;
      cons_data_q  <= cons_data_d;
      err_q        <= err_d;
    end
  end

endmodule
